// File: rtl/cycle_dispatch30_pkg.sv
// cycle_dispatch30_pkg: shared sizing and state encodings for the downlink dispatcher
package cycle_dispatch30_pkg;
    localparam int N_CH    = 30;
    localparam int USEDW_W = 13;
    localparam int DEPTH   = 8192;
    localparam int BURST   = 8;
    localparam int MARGIN  = 4;
    localparam int CH_W    = 5;
    localparam int BC_W    = 8;
    localparam int NEED    = 2 * BURST + MARGIN;
    typedef enum logic [1:0] {S_SEL = 2'd0, S_LO = 2'd1, S_HI = 2'd2} state_t;
endpackage

// File: rtl/cycle_dispatch30.sv
// cycle_dispatch30: splits 64-bit downlink words into 32-bit beats, round-robin bursts per channel
import cycle_dispatch30_pkg::*;
module cycle_dispatch30 (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dn_valid,
    input  logic [63:0]               dn_data,
    output logic                      dn_ready,
    input  logic [N_CH-1:0]           ch_en,
    input  logic [N_CH*USEDW_W-1:0]   ch_wrusedw,
    output logic [N_CH-1:0]           ch_wrreq,
    output logic [N_CH*32-1:0]        ch_data,
    output logic [4:0]                cur_ch,
    output logic                      burst_done
);
    state_t            state;
    logic [CH_W-1:0]   ptr;
    logic [BC_W-1:0]   beat_cnt;
    logic [31:0]       hi_buf;
    logic [USEDW_W:0]  room;
    logic              eligible;
    logic [CH_W-1:0]   ptr_nxt;
    assign room     = (USEDW_W+1)'(DEPTH) - {1'b0, ch_wrusedw[ptr*USEDW_W +: USEDW_W]};
    assign eligible = ch_en[ptr] && room >= (USEDW_W+1)'(NEED);
    assign ptr_nxt  = ptr == CH_W'(N_CH-1) ? '0 : ptr + 1'b1;
    assign dn_ready = state == S_LO;
    assign cur_ch   = ptr;
    // scan for an eligible channel, then alternate low/high beats for one burst
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_SEL;
            ptr        <= '0;
            beat_cnt   <= '0;
            hi_buf     <= '0;
            ch_wrreq   <= '0;
            ch_data    <= '0;
            burst_done <= 1'b0;
        end else begin
            ch_wrreq   <= '0;
            burst_done <= 1'b0;
            case (state)
                S_SEL: begin
                    if (eligible) begin
                        state    <= S_LO;
                        beat_cnt <= '0;
                    end else begin
                        ptr <= ptr_nxt;
                    end
                end
                S_LO: begin
                    if (dn_valid) begin
                        ch_wrreq             <= N_CH'(1) << ptr;
                        ch_data[ptr*32 +: 32] <= dn_data[31:0];
                        hi_buf               <= dn_data[63:32];
                        state                <= S_HI;
                    end
                end
                S_HI: begin
                    ch_wrreq             <= N_CH'(1) << ptr;
                    ch_data[ptr*32 +: 32] <= hi_buf;
                    if (beat_cnt == BC_W'(BURST-1)) begin
                        burst_done <= 1'b1;
                        ptr        <= ptr_nxt;
                        state      <= S_SEL;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                        state    <= S_LO;
                    end
                end
                default: state <= S_SEL;
            endcase
        end
    end
endmodule
